mult_datapath: RTL and testbench

Register-and-arithmetic datapath for the sequential signed add-shift multiplier, directly downstream of the multiplier `control` FSM. It holds:

- the sign-extension flop X;
- the accumulator A (high half of the product);
- the multiplier register B (low half);
- a 9-bit adder/subtractor.

It consumes the FSM strobes `Shift_En`, `Add_Sub9_En`, `fn_HiLow` and `clear` every cycle and exposes `{X, A, B}` to the hex-display logic, plus `M` (B[0]) back to the control path.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_datapath_if.sv | 39 +++
 rtl/mult_datapath_adder9.sv | 28 ++
 rtl/mult_datapath.sv | 115 +++++++++++
 tb/tb_mult_datapath.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the signed add-shift multiplier datapath.
// Optional sequence checker is enabled with MULT_SEQ_CHK_EN.
package mult_pkg;

  localparam int MULT_W = 8;

  // fn_HiLow encodes the adder operation directly
  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/mult_datapath_if.sv
// Strobe, operand and result bundle between the multiplier control FSM and its datapath.
// SeqErr exists only when MULT_SEQ_CHK_EN is defined.
interface mult_datapath_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
);

  logic             clear;
  logic             LoadB;
  logic             Shift_En;
  logic             Add_Sub9_En;
  logic             fn_HiLow;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             M;
`ifdef MULT_SEQ_CHK_EN
  logic             SeqErr;
`endif

  modport master (
    output clear, LoadB, Shift_En, Add_Sub9_En, fn_HiLow, S,
`ifdef MULT_SEQ_CHK_EN
    input  SeqErr,
`endif
    input  Aval, Bval, X, M
  );

  modport slave (
    input  clear, LoadB, Shift_En, Add_Sub9_En, fn_HiLow, S,
`ifdef MULT_SEQ_CHK_EN
    output SeqErr,
`endif
    output Aval, Bval, X, M
  );

endinterface

// File: rtl/mult_datapath_adder9.sv
// (WIDTH+1)-bit ripple-carry adder/subtractor; subtraction inverts b and injects a carry-in.
module adder9
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o
);

  logic carry;
  logic bx;

  // Carry-out of the top bit is intentionally dropped
  always_comb begin
    carry = sub_i;
    bx    = 1'b0;
    sum_o = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      bx       = b_i[i] ^ sub_i;
      sum_o[i] = a_i[i] ^ bx ^ carry;
      carry    = (a_i[i] & bx) | (carry & (a_i[i] ^ bx));
    end
  end

endmodule

// File: rtl/mult_datapath.sv
// X/A/B registers and strobe priority for the sequential signed multiplier.
// Defining MULT_SEQ_CHK_EN adds a shift counter and the sticky SeqErr flag.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic            Clk,
  input  logic            Reset,
  mult_datapath_if.slave  bus
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             x_q, x_d;
  logic [WIDTH:0]   sum;
  alu_op_e          op;
  logic             loadOrClear;

  assign op          = alu_op_e'(bus.fn_HiLow);
  assign loadOrClear = bus.clear | bus.LoadB;

  adder9 #(.WIDTH(WIDTH)) u_adder (
    .a_i   ({a_q[WIDTH-1], a_q}),
    .b_i   ({bus.S[WIDTH-1], bus.S}),
    .sub_i (op == SUB),
    .sum_o (sum)
  );

  // clear/LoadB beat add, add beats shift; add only acts when the multiplier bit is set
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    x_d = x_q;
    if (loadOrClear) begin
      if (bus.clear) begin
        a_d = '0;
        x_d = 1'b0;
      end
      if (bus.LoadB) begin
        b_d = bus.S;
      end
    end else if (bus.Add_Sub9_En) begin
      if (b_q[0]) begin
        x_d = sum[WIDTH];
        a_d = sum[WIDTH-1:0];
      end
    end else if (bus.Shift_En) begin
      a_d = {x_q, a_q[WIDTH-1:1]};
      b_d = {a_q[0], b_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q <= '0;
      b_q <= '0;
      x_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      x_q <= x_d;
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.X    = x_q;
  assign bus.M    = b_q[0];

`ifdef MULT_SEQ_CHK_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       shiftEff;

  assign shiftEff = bus.Shift_En & ~bus.Add_Sub9_En & ~loadOrClear;

  // A ninth shift or a simultaneous add+shift marks the sequence as broken until clear
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (loadOrClear) begin
      cnt_d = '0;
      if (bus.clear) begin
        err_d = 1'b0;
      end
    end else begin
      if (bus.Add_Sub9_En && bus.Shift_En) begin
        err_d = 1'b1;
      end
      if (shiftEff) begin
        if (cnt_q >= 4'd8) begin
          err_d = 1'b1;
        end
        if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.SeqErr = err_q;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath; SeqErr checks compile in with MULT_SEQ_CHK_EN.
module tb_mult_datapath;
  import mult_pkg::*;

  logic Clk;
  logic Reset;
  int   compareCount;
  int   mismatchCount;

  mult_datapath_if #(.WIDTH(MULT_W)) bus ();

  mult_datapath #(.WIDTH(MULT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of strobes, let the edge land, then return all strobes low
  task automatic applyStimulus(input logic clr, input logic ldb, input logic sh,
                               input logic add, input logic fn, input logic [7:0] s);
    bus.clear       = clr;
    bus.LoadB       = ldb;
    bus.Shift_En    = sh;
    bus.Add_Sub9_En = add;
    bus.fn_HiLow    = fn;
    bus.S           = s;
    @(posedge Clk);
    #1;
    bus.clear       = 1'b0;
    bus.LoadB       = 1'b0;
    bus.Shift_En    = 1'b0;
    bus.Add_Sub9_En = 1'b0;
    bus.fn_HiLow    = 1'b0;
  endtask

  task automatic runMultiply(input string tag, input logic [7:0] s, input logic [7:0] b,
                             input logic [15:0] expProd, input logic expX);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, (i == 7), s);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, s);
    end
    checkOutput({tag, "_prod"}, {16'h0, bus.Aval, bus.Bval}, {16'h0, expProd});
    checkOutput({tag, "_x"}, {31'h0, bus.X}, {31'h0, expX});
  endtask

  initial begin
    compareCount    = 0;
    mismatchCount   = 0;
    Reset           = 1'b0;
    bus.clear       = 1'b0;
    bus.LoadB       = 1'b0;
    bus.Shift_En    = 1'b0;
    bus.Add_Sub9_En = 1'b0;
    bus.fn_HiLow    = 1'b0;
    bus.S           = 8'h00;
    #12;
    checkOutput("rst_a", {24'h0, bus.Aval}, 32'h0);
    checkOutput("rst_b", {24'h0, bus.Bval}, 32'h0);
    checkOutput("rst_xm", {30'h0, bus.X, bus.M}, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Build A=0x5A, X=1, B=0x3C, then reset between edges
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hDA);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    checkOutput("pre_rst", {15'h0, bus.X, bus.Aval, bus.Bval}, 32'h15A3C);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("midrst_ab", {16'h0, bus.Aval, bus.Bval}, 32'h0);
    checkOutput("midrst_xm", {30'h0, bus.X, bus.M}, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // LoadB then clear
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("load_b", {24'h0, bus.Bval}, 32'hFD);
    checkOutput("load_a", {24'h0, bus.Aval}, 32'h0);
    checkOutput("load_xm", {30'h0, bus.X, bus.M}, 32'h1);

    // Single add and single subtract of 0x80 from zero
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    checkOutput("add80", {23'h0, bus.X, bus.Aval}, 32'h180);
    checkOutput("add80_b", {24'h0, bus.Bval}, 32'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
    checkOutput("sub80", {23'h0, bus.X, bus.Aval}, 32'h080);

    // Plain shift: {X,A,B} = {0,0x80,0x01} -> A=0x40, B=0x00
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("shift1", {15'h0, bus.X, bus.Aval, bus.Bval}, 32'h04000);

    runMultiply("mul_07xFD", 8'h07, 8'hFD, 16'hFFEB, 1'b1);
    runMultiply("mul_80x80", 8'h80, 8'h80, 16'h4000, 1'b0);
    runMultiply("mul_FFxFF", 8'hFF, 8'hFF, 16'h0001, 1'b0);
    runMultiply("mul_05x03", 8'h05, 8'h03, 16'h000F, 1'b0);

    // Result persists without strobes
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
    checkOutput("hold", {16'h0, bus.Aval, bus.Bval}, 32'h000F);

    // Add with M=0 holds; clear alongside add wins
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    checkOutput("add_m0", {15'h0, bus.X, bus.Aval, bus.Bval}, 32'h18002);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
    checkOutput("clr_add", {15'h0, bus.X, bus.Aval, bus.Bval}, 32'h00003);

`ifdef MULT_SEQ_CHK_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("seq_clr", {31'h0, bus.SeqErr}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    checkOutput("seq_8sh", {31'h0, bus.SeqErr}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("seq_9sh", {31'h0, bus.SeqErr}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    checkOutput("seq_reclr", {31'h0, bus.SeqErr}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05);
    checkOutput("seq_both", {31'h0, bus.SeqErr}, 32'h1);
    checkOutput("seq_both_ab", {15'h0, bus.X, bus.Aval, bus.Bval}, 32'h00501);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
